// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit.
//   - OPCODE_* constants for IR[6:2]
//   - FSM state and opcode-class enums
//   - datapath mux / alu_op / result_src / trap_cause encodings
//   - ctrl_out_t: the Moore output bundle, plus helper functions that
//     classify an opcode and decode outputs from (state, class)
package cpu_ctrl_pkg;

  localparam logic [4:0] OPCODE_LOAD    = 5'b00000;
  localparam logic [4:0] OPCODE_STORE   = 5'b01000;
  localparam logic [4:0] OPCODE_OP_IMM  = 5'b00100;
  localparam logic [4:0] OPCODE_OP      = 5'b01100;
  localparam logic [4:0] OPCODE_BRANCH  = 5'b11000;
  localparam logic [4:0] OPCODE_JAL     = 5'b11011;
  localparam logic [4:0] OPCODE_JALR    = 5'b11001;
  localparam logic [4:0] OPCODE_LUI     = 5'b01101;
  localparam logic [4:0] OPCODE_AUIPC   = 5'b00101;
  localparam logic [4:0] OPCODE_SYSTEM  = 5'b11100;
  localparam logic [4:0] OPCODE_CUSTOM0 = 5'b00010;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_CUSTOM = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    CLS_LOAD, CLS_STORE, CLS_ARITH_I, CLS_ARITH_R, CLS_BRANCH, CLS_JAL,
    CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_CUSTOM, CLS_SYSTEM, CLS_ILLEGAL
  } op_class_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;
  localparam logic [1:0] ALU_I   = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_RS1   = 2'd2;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  localparam logic [1:0] RES_ALU  = 2'd0;
  localparam logic [1:0] RES_MDR  = 2'd1;
  localparam logic [1:0] RES_LINK = 2'd2;
  localparam logic [1:0] RES_IMM  = 2'd3;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_SYSTEM  = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

  // ir_write and the fetch-time pc_write depend on mem_ready, so they are
  // not part of this registered bundle.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       addr_src;
    logic       mem_req;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       trap;
  } ctrl_out_t;

  function automatic op_class_e op_classify(logic [4:0] op, logic custom_en);
    op_class_e c;
    case (op)
      OPCODE_LOAD:    c = CLS_LOAD;
      OPCODE_STORE:   c = CLS_STORE;
      OPCODE_OP_IMM:  c = CLS_ARITH_I;
      OPCODE_OP:      c = CLS_ARITH_R;
      OPCODE_BRANCH:  c = CLS_BRANCH;
      OPCODE_JAL:     c = CLS_JAL;
      OPCODE_JALR:    c = CLS_JALR;
      OPCODE_LUI:     c = CLS_LUI;
      OPCODE_AUIPC:   c = CLS_AUIPC;
      OPCODE_SYSTEM:  c = CLS_SYSTEM;
      OPCODE_CUSTOM0: c = custom_en ? CLS_CUSTOM : CLS_ILLEGAL;
      default:        c = CLS_ILLEGAL;
    endcase
    return c;
  endfunction

  function automatic ctrl_out_t ctrl_decode(state_e s, op_class_e c);
    ctrl_out_t o;
    o = '0;
    case (s)
      S_FETCH: begin
        o.mem_req   = 1'b1;
        o.alu_src_b = SRCB_FOUR;
      end
      // Precompute PC+imm (branch/JAL target) while the class is decided.
      S_DECODE: begin
        o.alu_src_a = SRCA_OLDPC;
        o.alu_src_b = SRCB_IMM;
      end
      S_EXEC: begin
        case (c)
          CLS_LOAD, CLS_STORE: begin
            o.alu_src_a = SRCA_RS1;
            o.alu_src_b = SRCB_IMM;
          end
          CLS_ARITH_R: begin
            o.alu_src_a = SRCA_RS1;
            o.alu_op    = ALU_R;
          end
          CLS_ARITH_I: begin
            o.alu_src_a = SRCA_RS1;
            o.alu_src_b = SRCB_IMM;
            o.alu_op    = ALU_I;
          end
          CLS_BRANCH: begin
            o.alu_src_a     = SRCA_RS1;
            o.alu_op        = ALU_BR;
            o.pc_write_cond = 1'b1;
          end
          // Target already sits in the ALU output register from DECODE.
          CLS_JAL: o.pc_write = 1'b1;
          CLS_JALR: begin
            o.alu_src_a = SRCA_RS1;
            o.alu_src_b = SRCB_IMM;
            o.pc_write  = 1'b1;
          end
          CLS_AUIPC: begin
            o.alu_src_a = SRCA_OLDPC;
            o.alu_src_b = SRCB_IMM;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        o.mem_req   = 1'b1;
        o.addr_src  = 1'b1;
        o.mem_write = (c == CLS_STORE);
      end
      S_WB: begin
        o.reg_write = 1'b1;
        case (c)
          CLS_LOAD:          o.result_src = RES_MDR;
          CLS_JAL, CLS_JALR: o.result_src = RES_LINK;
          CLS_LUI:           o.result_src = RES_IMM;
          default:           o.result_src = RES_ALU;
        endcase
      end
      S_CUSTOM: o.alu_src_a = SRCA_RS1;
      S_TRAP:   o.trap      = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/ctrl_timeout_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : zero the count (wins over en)
//   en         : increment, holding at all-ones
//   cnt        : current count
module ctrl_timeout_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                    cnt_d = '0;
    else if (en && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB plus a
// fixed-latency CUSTOM slot and a sticky TRAP state.
//   clk, rst_n  : clock, synchronous active-low reset
//   op          : IR[6:2]
//   mem_ready   : memory handshake, looked at only in FETCH and MEM
//   pc_write, pc_write_cond, ir_write : PC / IR update strobes
//   addr_src, mem_req, mem_write      : memory port control
//   reg_write, alu_src_a/b, alu_op, result_src : datapath muxes
//   trap, trap_cause, state_o         : trap status and debug state
module multicycle_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int OP_W        = 5,
  parameter int ALU_OP_W    = 2,
  parameter int CUSTOM_EN   = 1,
  parameter int CUSTOM_LAT  = 3,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OP_W-1:0]     op,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                ir_write,
  output logic                addr_src,
  output logic                mem_req,
  output logic                mem_write,
  output logic                reg_write,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [1:0]          result_src,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic [2:0]          state_o
);

  localparam int TMO_W = 16;
  // With MEM_TIMEOUT = 0 this wraps to all-ones but is never used.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);
  localparam logic [3:0]       CUS_LAST = 4'(CUSTOM_LAT - 1);

  state_e     state_q, state_d;
  op_class_e  cls_q, cls_d;
  logic [1:0] cause_q, cause_d;
  ctrl_out_t  outs_q, outs_d;

  logic [TMO_W-1:0] tmo_cnt;
  logic [3:0]       cus_cnt;
  logic             mem_wait, tmo_hit, in_fetch, in_custom;

  assign in_fetch  = (state_q == S_FETCH);
  assign in_custom = (state_q == S_CUSTOM);
  assign mem_wait  = (in_fetch || state_q == S_MEM) && !mem_ready;
  // Fires in the Nth consecutive not-ready cycle; a ready in that same
  // cycle is a handshake instead because mem_wait is then low.
  assign tmo_hit   = (MEM_TIMEOUT != 0) && mem_wait && (tmo_cnt == TMO_LAST);

  // Any ready cycle leaves FETCH/MEM, so clearing on !mem_wait also
  // covers "cleared when the state is left".
  ctrl_timeout_counter #(.W(TMO_W)) u_tmo_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!mem_wait),
    .en    (mem_wait),
    .cnt   (tmo_cnt)
  );

  ctrl_timeout_counter #(.W(4)) u_cus_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!in_custom),
    .en    (in_custom),
    .cnt   (cus_cnt)
  );

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    cause_d = cause_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
        else if (tmo_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        cls_d = op_classify(5'(op), CUSTOM_EN != 0);
        case (cls_d)
          CLS_CUSTOM: state_d = S_CUSTOM;
          CLS_SYSTEM: begin
            state_d = S_TRAP;
            cause_d = CAUSE_SYSTEM;
          end
          CLS_ILLEGAL: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cls_q)
          CLS_LOAD, CLS_STORE: state_d = S_MEM;
          CLS_BRANCH:          state_d = S_FETCH;
          default:             state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready) state_d = (cls_q == CLS_STORE) ? S_FETCH : S_WB;
        else if (tmo_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_WB:     state_d = S_FETCH;
      S_CUSTOM: if (cus_cnt == CUS_LAST) state_d = S_WB;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
    // Outputs are registered from the next state so they line up with state_q.
    outs_d = ctrl_decode(state_d, cls_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cls_q   <= CLS_ILLEGAL;
      cause_q <= CAUSE_NONE;
      outs_q  <= ctrl_decode(S_FETCH, CLS_ILLEGAL);
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cause_q <= cause_d;
      outs_q  <= outs_d;
    end
  end

  // Fetch handshake strobes are the only terms that follow mem_ready.
  assign ir_write      = in_fetch && mem_ready;
  assign pc_write      = outs_q.pc_write || (in_fetch && mem_ready);
  assign pc_write_cond = outs_q.pc_write_cond;
  assign addr_src      = outs_q.addr_src;
  assign mem_req       = outs_q.mem_req;
  assign mem_write     = outs_q.mem_write;
  assign reg_write     = outs_q.reg_write;
  assign alu_src_a     = outs_q.alu_src_a;
  assign alu_src_b     = outs_q.alu_src_b;
  assign alu_op        = ALU_OP_W'(outs_q.alu_op);
  assign result_src    = outs_q.result_src;
  assign trap          = outs_q.trap;
  assign trap_cause    = cause_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

  logic       clk, rst_n, mem_ready;
  logic [4:0] op;

  logic       pc_write, pc_write_cond, ir_write, addr_src, mem_req, mem_write, reg_write, trap;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src, trap_cause;
  logic [2:0] state_o;

  logic       b_pc_write, b_pc_write_cond, b_ir_write, b_addr_src, b_mem_req, b_mem_write, b_reg_write, b_trap;
  logic [1:0] b_alu_src_a, b_alu_src_b, b_alu_op, b_result_src, b_trap_cause;
  logic [2:0] b_state_o;

  int n_chk = 0;
  int n_pass = 0;

  multicycle_control_unit #(
    .OP_W(5), .ALU_OP_W(2), .CUSTOM_EN(1), .CUSTOM_LAT(3), .MEM_TIMEOUT(4)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .addr_src(addr_src), .mem_req(mem_req), .mem_write(mem_write),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .result_src(result_src), .trap(trap),
    .trap_cause(trap_cause), .state_o(state_o)
  );

  // Custom opcode disabled: must trap as illegal.
  multicycle_control_unit #(
    .OP_W(5), .ALU_OP_W(2), .CUSTOM_EN(0), .CUSTOM_LAT(3), .MEM_TIMEOUT(0)
  ) u_dut_noc (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .pc_write(b_pc_write), .pc_write_cond(b_pc_write_cond), .ir_write(b_ir_write),
    .addr_src(b_addr_src), .mem_req(b_mem_req), .mem_write(b_mem_write),
    .reg_write(b_reg_write), .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b),
    .alu_op(b_alu_op), .result_src(b_result_src), .trap(b_trap),
    .trap_cause(b_trap_cause), .state_o(b_state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [17:0] outs;
  assign outs = {pc_write, pc_write_cond, ir_write, addr_src, mem_req, mem_write,
                 reg_write, alu_src_a, alu_src_b, alu_op, result_src, trap, trap_cause};

  function automatic logic [17:0] v(logic pcw, logic pcc, logic irw, logic as, logic mr,
                                    logic mw, logic rw, logic [1:0] a, logic [1:0] b,
                                    logic [1:0] aop, logic [1:0] rs, logic tr, logic [1:0] tc);
    return {pcw, pcc, irw, as, mr, mw, rw, a, b, aop, rs, tr, tc};
  endfunction

  localparam logic [2:0] ST_F = 3'd0, ST_D = 3'd1, ST_E = 3'd2, ST_M = 3'd3,
                         ST_W = 3'd4, ST_C = 3'd5, ST_T = 3'd6;

  logic [17:0] F0, F1, DEC, EX_R, EX_LS, EX_BR, WB_ALU, WB_MDR, MEM_LD, MEM_ST, CUS,
               TR1, TR2, TR3;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Drive one cycle's inputs, check state and outputs, then cross the edge.
  task automatic cyc(input string tag, input logic [4:0] o, input logic r,
                     input logic [2:0] es, input logic [17:0] ev);
    op = o;
    mem_ready = r;
    #1;
    chk({tag, ".st"}, 32'(state_o), 32'(es));
    chk({tag, ".out"}, 32'(outs), 32'(ev));
    @(posedge clk);
    #1;
  endtask

  task automatic rst_cyc();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  localparam logic [4:0] OP_R = 5'b01100, OP_LD = 5'b00000, OP_ST = 5'b01000,
                         OP_BR = 5'b11000, OP_BAD = 5'b11111, OP_SYS = 5'b11100,
                         OP_CUS = 5'b00010;

  initial begin
    F0     = v(0,0,0,0,1,0,0, 2'd0,2'd2,2'd0,2'd0, 0,2'd0);
    F1     = v(1,0,1,0,1,0,0, 2'd0,2'd2,2'd0,2'd0, 0,2'd0);
    DEC    = v(0,0,0,0,0,0,0, 2'd1,2'd1,2'd0,2'd0, 0,2'd0);
    EX_R   = v(0,0,0,0,0,0,0, 2'd2,2'd0,2'd2,2'd0, 0,2'd0);
    EX_LS  = v(0,0,0,0,0,0,0, 2'd2,2'd1,2'd0,2'd0, 0,2'd0);
    EX_BR  = v(0,1,0,0,0,0,0, 2'd2,2'd0,2'd1,2'd0, 0,2'd0);
    WB_ALU = v(0,0,0,0,0,0,1, 2'd0,2'd0,2'd0,2'd0, 0,2'd0);
    WB_MDR = v(0,0,0,0,0,0,1, 2'd0,2'd0,2'd0,2'd1, 0,2'd0);
    MEM_LD = v(0,0,0,1,1,0,0, 2'd0,2'd0,2'd0,2'd0, 0,2'd0);
    MEM_ST = v(0,0,0,1,1,1,0, 2'd0,2'd0,2'd0,2'd0, 0,2'd0);
    CUS    = v(0,0,0,0,0,0,0, 2'd2,2'd0,2'd0,2'd0, 0,2'd0);
    TR1    = v(0,0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 1,2'd1);
    TR2    = v(0,0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 1,2'd2);
    TR3    = v(0,0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 1,2'd3);

    rst_n = 1'b0;
    op = 5'd0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    cyc("rst", OP_R, 0, ST_F, F0);

    // Arith_R, zero-wait: 4 cycles
    cyc("r.f", OP_R, 1, ST_F, F1);
    cyc("r.d", OP_R, 1, ST_D, DEC);
    cyc("r.e", OP_R, 1, ST_E, EX_R);
    cyc("r.w", OP_R, 1, ST_W, WB_ALU);

    // Load: 2 fetch waits, 1 mem wait -> 8 cycles
    cyc("ld.f0", OP_LD, 0, ST_F, F0);
    cyc("ld.f1", OP_LD, 0, ST_F, F0);
    cyc("ld.f2", OP_LD, 1, ST_F, F1);
    cyc("ld.d",  OP_LD, 1, ST_D, DEC);
    cyc("ld.e",  OP_LD, 1, ST_E, EX_LS);
    cyc("ld.m0", OP_LD, 0, ST_M, MEM_LD);
    cyc("ld.m1", OP_LD, 1, ST_M, MEM_LD);
    cyc("ld.w",  OP_LD, 1, ST_W, WB_MDR);

    // Store then Branch
    cyc("st.f", OP_ST, 1, ST_F, F1);
    cyc("st.d", OP_ST, 1, ST_D, DEC);
    cyc("st.e", OP_ST, 1, ST_E, EX_LS);
    cyc("st.m", OP_ST, 1, ST_M, MEM_ST);
    cyc("br.f", OP_BR, 1, ST_F, F1);
    cyc("br.d", OP_BR, 1, ST_D, DEC);
    cyc("br.e", OP_BR, 1, ST_E, EX_BR);

    // Illegal opcode: trap held 20 cycles regardless of mem_ready
    cyc("ill.f", OP_BAD, 1, ST_F, F1);
    cyc("ill.d", OP_BAD, 1, ST_D, DEC);
    for (int i = 0; i < 20; i++) cyc("ill.t", OP_R, logic'(i % 2), ST_T, TR1);

    // Reset while in TRAP
    rst_cyc();
    cyc("rst_trap", OP_SYS, 0, ST_F, F0);

    // SYSTEM -> cause 2
    cyc("sys.f", OP_SYS, 1, ST_F, F1);
    cyc("sys.d", OP_SYS, 1, ST_D, DEC);
    cyc("sys.t", OP_SYS, 1, ST_T, TR2);
    rst_cyc();

    // Custom: 6 cycles on u_dut; illegal on u_dut_noc
    cyc("cus.f", OP_CUS, 1, ST_F, F1);
    cyc("cus.d", OP_CUS, 1, ST_D, DEC);
    for (int i = 0; i < 3; i++) begin
      chk("noc.st", 32'(b_state_o), 32'(ST_T));
      chk("noc.cause", 32'(b_trap_cause), 32'd1);
      cyc("cus.c", OP_CUS, 1, ST_C, CUS);
    end
    cyc("cus.w", OP_CUS, 1, ST_W, WB_ALU);
    rst_cyc();
    cyc("rst_cus", OP_LD, 0, ST_F, F0);

    // MEM timeout after 4 not-ready cycles
    cyc("to.f", OP_LD, 1, ST_F, F1);
    cyc("to.d", OP_LD, 1, ST_D, DEC);
    cyc("to.e", OP_LD, 1, ST_E, EX_LS);
    for (int i = 0; i < 4; i++) cyc("to.m", OP_LD, 0, ST_M, MEM_LD);
    cyc("to.t", OP_LD, 0, ST_T, TR3);
    cyc("to.t2", OP_LD, 1, ST_T, TR3);
    rst_cyc();
    cyc("rst_to", OP_LD, 0, ST_F, F0);

    // Reset during MEM
    cyc("rm.f", OP_LD, 1, ST_F, F1);
    cyc("rm.d", OP_LD, 1, ST_D, DEC);
    cyc("rm.e", OP_LD, 1, ST_E, EX_LS);
    cyc("rm.m", OP_LD, 0, ST_M, MEM_LD);
    rst_cyc();
    cyc("rst_mem", OP_LD, 0, ST_F, F0);

    // Ready on the 4th wait cycle: handshake wins over timeout
    cyc("hw.f", OP_LD, 1, ST_F, F1);
    cyc("hw.d", OP_LD, 1, ST_D, DEC);
    cyc("hw.e", OP_LD, 1, ST_E, EX_LS);
    for (int i = 0; i < 3; i++) cyc("hw.m", OP_LD, 0, ST_M, MEM_LD);
    cyc("hw.m3", OP_LD, 1, ST_M, MEM_LD);
    cyc("hw.w", OP_LD, 1, ST_W, WB_MDR);
    cyc("hw.f2", OP_LD, 0, ST_F, F0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multi-cycle successor to the single-cycle RV32I control decoder. A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback. It drives the shared-datapath muxes, a handshaked memory port, a fixed-latency custom-opcode slot and a trap output. It sits between the instruction register (`op` = IR[6:2]) and the shared ALU/register-file/memory datapath of the RISC-V CPU.

## Interface
Parameters:
- `OP_W`, 5: opcode field width (IR[6:2]).
- `ALU_OP_W`, 2: width of `alu_op` to the ALU control.
- `CUSTOM_EN`, 1: 1 = custom-0 opcode (`00010`) is legal; 0 = it traps as illegal.
- `CUSTOM_LAT`, 3: cycles spent in CUSTOM state, 1..15.
- `MEM_TIMEOUT`, 0: maximum cycles waiting for `mem_ready`; 0 disables the timeout.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `op` in `OP_W`: opcode of the instruction held in IR.
- `mem_ready` in 1: memory accepts or completes the current request this cycle.
- `pc_write` out 1: unconditional PC update.
- `pc_write_cond` out 1: PC update if ALU zero (branch).
- `ir_write` out 1: latch fetched word into IR.
- `addr_src` out 1: memory address select; 0 = PC, 1 = ALU output register.
- `mem_req` out 1: memory request.
- `mem_write` out 1: request is a write.
- `reg_write` out 1: register-file write enable.
- `alu_src_a` out 2: A operand select; 0 = PC, 1 = old PC, 2 = rs1.
- `alu_src_b` out 2: B operand select; 0 = rs2, 1 = imm, 2 = constant 4.
- `alu_op` out `ALU_OP_W`: 00 = add, 01 = branch compare, 10 = R-type funct, 11 = I-type funct.
- `result_src` out 2: writeback source; 0 = ALU output register, 1 = MDR, 2 = link (old PC+4), 3 = imm.
- `trap` out 1: high while in TRAP.
- `trap_cause` out 2: 0 = none, 1 = illegal opcode, 2 = SYSTEM, 3 = memory timeout.
- `state_o` out 3: current state, for debug.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, CUSTOM, TRAP.
- Reset (`rst_n` = 0 at an edge) forces FETCH, clears the timeout and custom counters and clears `trap_cause`. This holds mid-instruction and in TRAP.
- All outputs are Moore outputs, decoded from the state and registered `op` class only.
- Every output is 0 unless listed for the current state. After reset the state is FETCH, so only the FETCH outputs are asserted.
- FETCH: `mem_req`=1, `addr_src`=0, `alu_src_a`=0, `alu_src_b`=2, `alu_op`=00.
  - When `mem_ready`=1, `ir_write`=1 and `pc_write`=1 that cycle; next state DECODE.
- DECODE: latch the opcode class; `alu_src_a`=1, `alu_src_b`=1, `alu_op`=00 (branch target). Next state by class:
  - Load, Store, Arith_I, Arith_R, Branch, JAL, JALR, LUI, AUIPC go to EXEC.
  - Custom goes to CUSTOM when `CUSTOM_EN`=1.
  - SYSTEM goes to TRAP with cause 2.
  - Any other opcode goes to TRAP with cause 1.
- EXEC, by class:
  - Load/Store: `alu_src_a`=2, `alu_src_b`=1, `alu_op`=00; next MEM.
  - Arith_R: `alu_src_a`=2, `alu_src_b`=0, `alu_op`=10; next WB.
  - Arith_I: `alu_src_a`=2, `alu_src_b`=1, `alu_op`=11; next WB.
  - Branch: `alu_src_a`=2, `alu_src_b`=0, `alu_op`=01, `pc_write_cond`=1; next FETCH. No register write.
  - JAL: `pc_write`=1, with ALU output = PC+imm from DECODE; next WB.
  - JALR: `alu_src_a`=2, `alu_src_b`=1, `pc_write`=1; next WB.
  - AUIPC: `alu_src_a`=1, `alu_src_b`=1; next WB.
  - LUI: next WB.
- MEM: `mem_req`=1, `addr_src`=1, `mem_write`=1 for Store. Hold until `mem_ready`=1.
  - Store then goes to FETCH.
  - Load then goes to WB.
- WB: `reg_write`=1.
  - `result_src`: Load = 1, JAL/JALR = 2, LUI = 3, all others = 0.
  - Next state FETCH.
- CUSTOM: counter runs from 0 to `CUSTOM_LAT`-1, `alu_src_a`=2, `alu_src_b`=0. Then WB with `result_src`=0.
- Timeout: a counter increments each cycle FETCH or MEM waits with `mem_ready`=0.
  - It clears when the state is left.
  - If `MEM_TIMEOUT`≠0 and the count reaches `MEM_TIMEOUT`, go to TRAP with cause 3 and drop `mem_req`.
- TRAP: `trap`=1 and `trap_cause` held; the FSM stays until reset.

## Timing
- Cycles per instruction with zero-wait memory: Branch 3; R/I/LUI/AUIPC/JAL/JALR 4; Store 4; Load 5; Custom 3+`CUSTOM_LAT`.
- Each cycle with `mem_ready`=0 in FETCH or MEM adds one cycle.
- `mem_ready` is sampled only while `mem_req`=1; it is ignored in all other states.
- `mem_req`, `addr_src` and `mem_write` stay stable from assertion until the handshake cycle.
- With `MEM_TIMEOUT`=N, TRAP is entered at the edge after N consecutive not-ready cycles.
- If `mem_ready` rises in the same cycle the count reaches N, the handshake wins.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - the `OPCODE_*` constants;
  - the state enum;
  - the `alu_op`, `result_src`, `alu_src_*` and `trap_cause` encodings.
- One sub-module, `ctrl_timeout_counter`: a saturating counter with clear, instanced for both the memory timeout and the CUSTOM latency.

## Test plan
- Arith_R (`op`=01100), `mem_ready` tied 1: FETCH→DECODE→EXEC→WB→FETCH in 4 cycles; `reg_write`=1 only in WB; `alu_op`=10 in EXEC.
- Load with 2 wait cycles in FETCH and 1 in MEM: 8 cycles total; `ir_write` pulses once; `result_src`=1 in WB.
- Store then Branch: Store has `mem_write`=1 and `reg_write` never 1. Branch is 3 cycles with `pc_write_cond`=1 in EXEC and `reg_write` never 1.
- Illegal opcodes: `op`=11111 gives `trap`=1, `trap_cause`=1, held for 20 cycles. SYSTEM gives cause 2. Custom with `CUSTOM_EN`=0 gives cause 1.
- Custom and timeout, with `CUSTOM_LAT`=3 and `MEM_TIMEOUT`=4:
  - custom instruction takes 6 cycles with WB `result_src`=0;
  - `mem_ready` held 0 in MEM gives TRAP cause 3 after 4 cycles.
- `rst_n`=0 asserted during MEM and during TRAP: state FETCH at the next edge, `trap`=0, all outputs at their FETCH values.
